// File: rtl/imem_loader.sv
// Instruction memory loader: assembles a big-endian UART byte stream into words,
// writes them from address 0 up to the HALT word, then hands the address port to the CPU.
module imem_loader #(
    parameter int NBITS  = 32,
    parameter int CELDAS = 60
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_load_start,
    input  logic [7:0]       i_rx_data,
    input  logic             i_rx_valid,
    input  logic [NBITS-1:0] i_cpu_PC,
    output logic [NBITS-1:0] o_mem_addr,
    output logic [NBITS-1:0] o_mem_wdata,
    output logic             o_mem_we,
    output logic             o_cpu_enable,
    output logic             o_loading,
    output logic             o_done,
    output logic             o_error,
    output logic [NBITS-1:0] o_word_count
);

    // state | meaning
    // IDLE  | waiting for a load request, bytes ignored
    // LOAD  | assembling bytes and writing words
    // RUN   | HALT written, CPU owns the address port
    // ERROR | image overran the memory, CPU held off
    typedef enum logic [1:0] {IDLE, LOAD, RUN, ERROR} state_t;

    localparam int               LAST_I   = ((CELDAS - 4) / 4) * 4;
    localparam logic [NBITS-1:0] LAST_ADR = NBITS'(LAST_I);
    localparam logic [NBITS-1:0] HALT     = {NBITS{1'b1}};

    state_t           state;
    logic [1:0]       byte_cnt;
    logic [23:0]      asm_reg;
    logic [NBITS-1:0] wr_addr;
    logic [NBITS-1:0] addr_q;
    logic [NBITS-1:0] full_word;
    logic [NBITS-1:0] next_addr;

    always_comb begin
        full_word = NBITS'({asm_reg, i_rx_data});
        next_addr = wr_addr + NBITS'(4);
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state        <= IDLE;
            byte_cnt     <= 2'd0;
            asm_reg      <= 24'd0;
            wr_addr      <= '0;
            addr_q       <= '0;
            o_mem_wdata  <= '0;
            o_mem_we     <= 1'b0;
            o_cpu_enable <= 1'b0;
            o_loading    <= 1'b0;
            o_done       <= 1'b0;
            o_error      <= 1'b0;
            o_word_count <= '0;
        end else begin
            o_mem_we <= 1'b0;
            if (i_load_start) begin
                // start beats a coincident byte and discards any partial word
                state        <= LOAD;
                byte_cnt     <= 2'd0;
                wr_addr      <= '0;
                addr_q       <= '0;
                o_word_count <= '0;
                o_cpu_enable <= 1'b0;
                o_loading    <= 1'b1;
                o_done       <= 1'b0;
                o_error      <= 1'b0;
            end else if (state == LOAD && i_rx_valid) begin
                if (byte_cnt == 2'd3) begin
                    o_mem_we     <= 1'b1;
                    o_mem_wdata  <= full_word;
                    addr_q       <= wr_addr;
                    o_word_count <= o_word_count + NBITS'(1);
                    wr_addr      <= next_addr;
                    byte_cnt     <= 2'd0;
                    if (full_word == HALT) begin
                        state        <= RUN;
                        o_loading    <= 1'b0;
                        o_done       <= 1'b1;
                        o_cpu_enable <= 1'b1;
                    end else if (next_addr > LAST_ADR) begin
                        state     <= ERROR;
                        o_loading <= 1'b0;
                        o_error   <= 1'b1;
                    end
                end else begin
                    asm_reg  <= {asm_reg[15:0], i_rx_data};
                    byte_cnt <= byte_cnt + 2'd1;
                end
            end
        end
    end

    // the HALT write lands in the first RUN cycle, so keep the loader address for that strobe
    assign o_mem_addr = (state == RUN && !o_mem_we) ? i_cpu_PC : addr_q;

endmodule
